midori64_decrypt: RTL and testbench
===================================

# midori64_decrypt

Iterative Midori64 decryption core: takes a 64-bit ciphertext and a 128-bit key and returns the 64-bit plaintext. It executes one inverse round per clock. It is the decrypt-side counterpart of the team's round-iterative Midori64 encryptor and uses the same cell ordering, Sb0 S-box and round-constant table. Valid/ready handshakes on both sides let it sit directly behind a ciphertext source and in front of a plaintext sink.

## Interface
- No parameters; block size is fixed at 64 bits, key size at 128 bits, and the round count at 16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ciphertext and key presented.
- in_ready  out  1  core idle; an input is accepted on the edge where in_valid & in_ready.
- ct  in  64  ciphertext. Cell s0 is bits [63:60], through s15 at bits [3:0]. Cells are ordered column-major.
- key  in  128  K0 = key[127:64], K1 = key[63:0].
- out_valid  out  1  pt holds a finished result.
- out_ready  in  1  sink accepts pt on the edge where out_valid & out_ready.
- pt  out  64  plaintext. Stable while out_valid is high.

## Operation
- Definitions:
  - WK = K0^K1.
  - RK_i = K_(i mod 2) ^ β_i, for i = 0..14. β_i is the Midori64 16-bit constant; each bit is XORed into the LSB of its cell.
  - SC: Sb0 applied to every cell, using 0..F -> C,A,D,3,E,B,F,7,8,9,1,5,0,2,4,6. Sb0 is an involution.
  - MC: each column multiplied by circ(0,1,1,1). MC is an involution.
  - SH: the encrypt shuffle, (s0..s15) <- (s0,s10,s5,s15,s14,s4,s11,s1,s9,s3,s12,s6,s7,s13,s2,s8). ISH is its inverse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On accept: capture key; state <= SC(ct ^ WK); r <= 14; go to RUN.
- RUN (inverse round r per cycle):
  - state <= SC(ISH(MC(state ^ RK_r))).
  - If r = 0: state <= state' ^ WK, where state' is the round result; go to DONE.
  - Otherwise r <= r-1.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE, with in_ready high the following cycle.
- Round counter: 4 bits, counts down 14..0 and never wraps. The key register is written only on accept.
- A new ciphertext is never accepted while in RUN or DONE; in_ready is 0 in those states.

## Timing
- Reset values: FSM = IDLE, in_ready = 1, out_valid = 0, pt = 0, r = 0, key register = 0.
- Latency: acceptance edge T0, then 15 RUN edges T1..T15. out_valid rises after T15, i.e. 15 cycles after acceptance.
- Back-to-back throughput: one block per 17 cycles. This covers accept, 15 rounds, and 1 output-handshake cycle with out_ready held high.
- Backpressure: out_valid and pt hold indefinitely while out_ready = 0.
- out_ready while out_valid = 0 is ignored. in_valid while in_ready = 0 is ignored, with no side effects.
- Simultaneous out_ready & in_valid in DONE: the output is consumed, and the input is not accepted that cycle.
- rst_n low at any time, including mid-RUN: all state returns to reset values immediately and asynchronously, and the partial result is discarded. The first edge after release may accept.
- pt is driven directly from the state register; there is no combinational path from ct to pt.

## Test plan
1. Zero vector: key = 0, ct = 3c9cceda2bbd449a -> pt = 0000000000000000; out_valid rises exactly 15 cycles after accept.
2. Published vector: key = 687ded3b3c85b3f35b1009863e2a8cbf, ct = 66bcdc6270d901cd -> pt = 42c20fd3b586879e.
3. Backpressure: hold out_ready = 0 for 20 cycles after done -> pt is stable and in_ready stays 0. In_valid pulses during that window are dropped; the next accept happens only after the output handshake.
4. Back-to-back: vectors 1 and 2 streamed with in_valid and out_ready held high -> outputs appear in order, 17 cycles apart, each correct.
5. Reset mid-run: assert rst_n low at round r = 7, then release and apply vector 2 -> out_valid = 0 and in_ready = 1 immediately on reset; pt from the new block is correct.
6. Round trip: 1000 random (key, pt) pairs encrypted by the team's Midori64 encryptor, then fed to this core -> the original pt is recovered for every pair.

Source files
------------

// File: rtl/midori64_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module      : midori64_decrypt_if
// Description : Ciphertext-in / plaintext-out valid-ready bundle for the
//               iterative Midori64 decryption core.
// Revision    : 1.0
// ============================================================================
interface midori64_decrypt_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ct;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  pt;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt
  );
endinterface
`default_nettype wire

// File: rtl/midori64_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : midori64_decrypt
// Description : Round-iterative Midori64 decryptor, one inverse round per clk.
// Revision    : 1.0
// ============================================================================
module midori64_decrypt (
  input  wire logic          clk,
  input  wire logic          rst_n,
  midori64_decrypt_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Source cell index for each output cell of the inverse shuffle.
  localparam logic [63:0] ISH_SRC = 64'h07E9_52BC_F816_AD43;

  state_t       r_fsm, w_fsm_nxt;
  logic [63:0]  r_state, w_state_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [63:0]  w_wk, w_rk, w_round;

  function automatic logic [3:0] sb0(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'hA;  4'h2: y = 4'hD;  4'h3: y = 4'h3;
      4'h4: y = 4'hE;  4'h5: y = 4'hB;  4'h6: y = 4'hF;  4'h7: y = 4'h7;
      4'h8: y = 4'h8;  4'h9: y = 4'h9;  4'hA: y = 4'h1;  4'hB: y = 4'h5;
      4'hC: y = 4'h0;  4'hD: y = 4'h2;  4'hE: y = 4'h4;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sc(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = sb0(x[4*j +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] mc(input logic [63:0] x);
    logic [63:0] y;
    logic [15:0] col;
    logic [3:0]  sum;
    for (int c = 0; c < 4; c++) begin
      col = x[63-16*c -: 16];
      sum = col[15:12] ^ col[11:8] ^ col[7:4] ^ col[3:0];
      y[63-16*c -: 16] = {sum ^ col[15:12], sum ^ col[11:8],
                          sum ^ col[7:4],   sum ^ col[3:0]};
    end
    return y;
  endfunction

  function automatic logic [63:0] ish(input logic [63:0] x);
    logic [63:0] y;
    int          src;
    for (int j = 0; j < 16; j++) begin
      src = int'(ISH_SRC[63-4*j -: 4]);
      y[63-4*j -: 4] = x[63-4*src -: 4];
    end
    return y;
  endfunction

  // Bit 15 of each constant belongs to cell s0.
  function automatic logic [15:0] beta(input logic [3:0] i);
    logic [15:0] b;
    case (i)
      4'd0:  b = 16'h15B3;  4'd1:  b = 16'h78C0;  4'd2:  b = 16'hA435;
      4'd3:  b = 16'h6213;  4'd4:  b = 16'h104F;  4'd5:  b = 16'hD170;
      4'd6:  b = 16'h0266;  4'd7:  b = 16'h0BCC;  4'd8:  b = 16'h9481;
      4'd9:  b = 16'h40B8;  4'd10: b = 16'h7197;  4'd11: b = 16'h228E;
      4'd12: b = 16'h5130;  4'd13: b = 16'hF8CA;  4'd14: b = 16'hDF90;
      default: b = 16'h0000;
    endcase
    return b;
  endfunction

  function automatic logic [63:0] spread(input logic [15:0] b);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) y[63-4*j -: 4] = {3'b000, b[15-j]};
    return y;
  endfunction

  assign w_wk    = r_key[127:64] ^ r_key[63:0];
  assign w_rk    = (r_rnd[0] ? r_key[63:0] : r_key[127:64]) ^ spread(beta(r_rnd));
  assign w_round = sc(ish(mc(r_state ^ w_rk)));
  assign bus.pt  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= 64'd0;
      r_rnd   <= 4'd0;
      r_key   <= 128'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_key   <= w_key_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt     = r_fsm;
    w_state_nxt   = r_state;
    w_rnd_nxt     = r_rnd;
    w_key_nxt     = r_key;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_key_nxt   = bus.key;
          w_state_nxt = sc(bus.ct ^ bus.key[127:64] ^ bus.key[63:0]);
          w_rnd_nxt   = 4'd14;
          w_fsm_nxt   = RUN;
        end
      end
      RUN: begin
        if (r_rnd == 4'd0) begin
          w_state_nxt = w_round ^ w_wk;
          w_fsm_nxt   = DONE;
        end else begin
          w_state_nxt = w_round;
          w_rnd_nxt   = r_rnd - 4'd1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_midori64_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_midori64_decrypt
// Description : Directed and round-trip checks for midori64_decrypt.
// Revision    : 1.0
// ============================================================================
module tb_midori64_decrypt;

  localparam logic [127:0] V1_KEY = 128'h0;
  localparam logic [63:0]  V1_CT  = 64'h3c9cceda2bbd449a;
  localparam logic [63:0]  V1_PT  = 64'h0;
  localparam logic [127:0] V2_KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
  localparam logic [63:0]  V2_CT  = 64'h66bcdc6270d901cd;
  localparam logic [63:0]  V2_PT  = 64'h42c20fd3b586879e;

  localparam logic [3:0]  SB[16]   = '{4'hC,4'hA,4'hD,4'h3,4'hE,4'hB,4'hF,4'h7,
                                       4'h8,4'h9,4'h1,4'h5,4'h0,4'h2,4'h4,4'h6};
  localparam int          SHP[16]  = '{0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8};
  localparam logic [15:0] BETA[15] = '{16'h15B3,16'h78C0,16'hA435,16'h6213,16'h104F,
                                       16'hD170,16'h0266,16'h0BCC,16'h9481,16'h40B8,
                                       16'h7197,16'h228E,16'h5130,16'hF8CA,16'hDF90};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  midori64_decrypt_if bus ();

  midori64_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encryptor used to build round-trip ciphertexts.
  function automatic logic [63:0] tb_sc(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 16; j++) y[63-4*j -: 4] = SB[x[63-4*j -: 4]];
    return y;
  endfunction

  function automatic logic [63:0] tb_mc(input logic [63:0] x);
    logic [63:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[63-16*c-4*r -: 4] = x[63-16*c-4*((r+1)%4) -: 4] ^ x[63-16*c-4*((r+2)%4) -: 4]
                            ^ x[63-16*c-4*((r+3)%4) -: 4];
    return y;
  endfunction

  function automatic logic [63:0] encrypt(input logic [127:0] k, input logic [63:0] p);
    logic [63:0] s, t, wk, rk;
    wk = k[127:64] ^ k[63:0];
    s  = p ^ wk;
    for (int i = 0; i < 15; i++) begin
      s = tb_sc(s);
      for (int j = 0; j < 16; j++) t[63-4*j -: 4] = s[63-4*SHP[j] -: 4];
      s  = tb_mc(t);
      rk = (i % 2 == 0) ? k[127:64] : k[63:0];
      for (int j = 0; j < 16; j++) rk[60-4*j] = rk[60-4*j] ^ BETA[i][15-j];
      s = s ^ rk;
    end
    return tb_sc(s) ^ wk;
  endfunction

  task automatic run_block(input logic [127:0] k, input logic [63:0] c,
                           output logic [63:0] p, output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    bus.key = k; bus.ct = c; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin step(); lat++; end
    p = bus.pt;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0]  p, rp;
    logic [127:0] rk;
    int           lat, acc, n;
    int           ov_seen[2];
    logic [63:0]  ov_pt[2];

    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ct = '0; bus.key = '0;
    step(); step();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_pt", bus.pt, 64'd0);
    rst_n = 1'b1;
    step();

    // Zero vector with exact latency and busy in_ready.
    bus.key = V1_KEY; bus.ct = V1_CT; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("v1_busy_in_ready", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin step(); lat++; end
    chk("v1_latency", 64'(lat), 64'd15);
    chk("v1_pt", bus.pt, V1_PT);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    chk("v1_post_handshake_ready", 64'(bus.in_ready), 64'd1);

    run_block(V2_KEY, V2_CT, p, lat);
    chk("v2_pt", p, V2_PT);
    chk("v2_latency", 64'(lat), 64'd15);

    // Backpressure with dropped in_valid pulses.
    run_block_hold: begin
      bus.key = V2_KEY; bus.ct = V2_CT; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin step(); lat++; end
      for (int i = 0; i < 20; i++) begin
        bus.in_valid = (i % 4 == 1);
        bus.ct = {$urandom(), $urandom()};
        bus.key = 128'h0;
        step();
        chk("bp_pt_stable", bus.pt, V2_PT);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    // Consume and offer simultaneously: only the consume takes effect.
    bus.in_valid = 1'b1; bus.key = V1_KEY; bus.ct = V1_CT; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("simul_out_valid", 64'(bus.out_valid), 64'd0);
    chk("simul_not_accepted", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_accept", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin step(); lat++; end
    chk("bp_next_latency", 64'(lat), 64'd15);
    chk("bp_next_pt", bus.pt, V1_PT);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Back-to-back streaming.
    acc = 0; n = 0;
    ov_seen[0] = -1; ov_seen[1] = -1; ov_pt[0] = '0; ov_pt[1] = '0;
    bus.key = V1_KEY; bus.ct = V1_CT; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_valid && bus.in_ready) acc++;
      step();
      if (acc == 1) begin bus.key = V2_KEY; bus.ct = V2_CT; end
      if (acc == 2) bus.in_valid = 1'b0;
      if (bus.out_valid && n < 2) begin ov_seen[n] = i; ov_pt[n] = bus.pt; n++; end
    end
    bus.out_ready = 1'b0;
    chk("b2b_count", 64'(n), 64'd2);
    chk("b2b_first_pt", ov_pt[0], V1_PT);
    chk("b2b_second_pt", ov_pt[1], V2_PT);
    chk("b2b_spacing", 64'(ov_seen[1] - ov_seen[0]), 64'd17);

    // Asynchronous reset at round 7.
    bus.key = V1_KEY; bus.ct = V1_CT; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_pt", bus.pt, 64'd0);
    step();
    rst_n = 1'b1;
    run_block(V2_KEY, V2_CT, p, lat);
    chk("rst_then_v2_pt", p, V2_PT);
    chk("rst_then_v2_latency", 64'(lat), 64'd15);

    // Round trip against the reference encryptor.
    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom()};
      run_block(rk, encrypt(rk, rp), p, lat);
      chk("roundtrip_pt", p, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
